qic117_step_encoder: RTL
========================

Name: qic117_step_encoder

Overview:
- Host-side QIC-117 command transmitter. It converts a 6-bit command code into a train of N STEP pulses, then holds STEP idle for a terminating gap so the drive's pulse-count timeout fires.
- It sits between the FDC register/command logic and the drive STEP pad, and is the counterpart of the drive-side pulse-count decoder.
- Pad polarity and inversion are handled outside this block.

Parameters:
- STEP_WIDTH_CYC, 400, STEP high time in clk cycles (4 us at 100 MHz); must be >= 1.
- STEP_PERIOD_CYC, 300000, rising-edge-to-rising-edge spacing in clk cycles (3 ms); must be > STEP_WIDTH_CYC.
- CMD_GAP_CYC, 12000000, quiet time after the last falling edge before completion (120 ms); must be >= 1.
- CNT_W, 24, timing counter width; must hold max(STEP_PERIOD_CYC, CMD_GAP_CYC).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_code  in  6  command code = number of STEP pulses, valid range 1..48
- cmd_start  in  1  request; sampled only when busy=0
- abort  in  1  terminate the pulse train early
- step_out  out  1  STEP pulse, active high
- busy  out  1  high from accept until completion
- done  out  1  one-cycle strobe on completion (normal or aborted)
- aborted  out  1  qualifies done; held until the next accept
- cmd_error  out  1  one-cycle strobe on a rejected start
- pulses_sent  out  6  rising edges issued for the current/last command

Behaviour:
- Reset values: step_out=0, busy=0, done=0, aborted=0, cmd_error=0, pulses_sent=0, FSM=IDLE, counters=0. Reset mid-train drops step_out at once; no gap is enforced after reset.
- States: IDLE, STEP_HI, STEP_LO, GAP.
- IDLE, cmd_start=1, cmd_code in 1..48 (accept at edge T):
  - latch the code; pulses_sent=0; aborted=0; busy=1 from T+1.
  - enter STEP_HI; step_out=1 at cycle T+1.
- IDLE, cmd_start=1, cmd_code 0 or 49..63: cmd_error=1 for one cycle, stay IDLE, no pulse. pulses_sent and aborted are unchanged.
- cmd_start while busy=1 is ignored, with no error.
- STEP_HI:
  - step_out=1 for exactly STEP_WIDTH_CYC cycles.
  - pulses_sent increments in the first cycle of each high phase and saturates at the latched code.
  - Exit to STEP_LO if more pulses remain, otherwise to GAP.
- STEP_LO: step_out=0 for STEP_PERIOD_CYC-STEP_WIDTH_CYC cycles, then STEP_HI. Pulse k (1-based) rises at T+1+(k-1)*STEP_PERIOD_CYC.
- GAP:
  - step_out=0 for CMD_GAP_CYC cycles, counted from the first low cycle after the last pulse (T+(N-1)*P+W+1).
  - On the following cycle: done=1, busy=0, return to IDLE.
  - A new cmd_start can be accepted in that same done cycle.
- abort=1 in STEP_HI or STEP_LO:
  - step_out=0 on the next cycle; aborted=1.
  - Enter GAP with a full CMD_GAP_CYC count, so the drive sees a clean terminator. The partial pulse count stays in pulses_sent.
  - abort in GAP or IDLE has no effect.
- abort and cmd_start asserted together in IDLE: start wins and abort is ignored that cycle.
- pulses_sent always equals the number of rising edges on step_out since the last accept.
- All counters are unsigned CNT_W bits. Each load is value-1 with a terminal at 0, so there is no wrap-around.

Test Plan:
Bench parameters: W=4, P=10, G=50.
- Normal, code 3, cmd_start at T:
  - step_out high during T+1..T+4, T+11..T+14 and T+21..T+24.
  - busy high T+1..T+74; done=1 and busy=0 at T+75.
  - pulses_sent=3, aborted=0.
- Boundaries:
  - code 1 gives one pulse and done at T+55.
  - code 48 gives 48 pulses, last rise at T+471, done at T+525.
- Invalid codes:
  - code 0 gives a cmd_error strobe, busy stays 0, step_out stays 0.
  - code 49 gives the same.
  - code 63 gives the same.
- Abort, code 10:
  - abort at T+16 (during STEP_LO after pulse 2): no further rising edge, pulses_sent=2.
  - done with aborted=1 at T+67 (GAP occupies T+17..T+66).
  - A second abort during GAP does not change the timing.
- Busy and back-to-back:
  - cmd_start with code 5 during a busy code-3 command is ignored; exactly 3 pulses appear.
  - cmd_start with code 2 in the done cycle is accepted, and its first pulse rises the next cycle.
- Reset mid-command:
  - reset_n low during STEP_HI of pulse 2: step_out=0 and busy=0 asynchronously.
  - After release the block is IDLE and accepts a new command normally.

Source files
------------

// File: rtl/qic117_step_encoder.sv
// rtl/qic117_step_encoder.sv - QIC-117 host command transmitter: cmd code to STEP pulse train plus gap
// Emits N STEP pulses for a 6-bit command code, then holds STEP low for the terminating gap.
module qic117_step_encoder #(
  parameter int unsigned STEP_WIDTH_CYC  = 400,
  parameter int unsigned STEP_PERIOD_CYC = 300000,
  parameter int unsigned CMD_GAP_CYC     = 12000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] cmd_code,
  input  logic       cmd_start,
  input  logic       abort,
  output logic       step_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       cmd_error,
  output logic [5:0] pulses_sent
);

  localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(STEP_WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LOAD  = CNT_W'(STEP_PERIOD_CYC - STEP_WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CMD_GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO, GAP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       code_q;
  logic [5:0]       pulses_q;
  logic             step_q, busy_q, done_q, aborted_q, cmd_error_q;
  logic             code_valid;
  logic             cnt_zero;
  logic             last_pulse;

  assign code_valid = (cmd_code != 6'd0) && (cmd_code <= 6'd48);
  assign cnt_zero   = (cnt_q == '0);
  assign last_pulse = (pulses_q == code_q);

  // pulses_q is bumped on the same edge that raises STEP, so it tracks rising edges exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      pulses_q    <= '0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            if (code_valid) begin
              code_q    <= cmd_code;
              pulses_q  <= 6'd1;
              aborted_q <= 1'b0;
              busy_q    <= 1'b1;
              step_q    <= 1'b1;
              cnt_q     <= HI_LOAD;
              state_q   <= STEP_HI;
            end else begin
              cmd_error_q <= 1'b1;
            end
          end
        end
        STEP_HI: begin
          if (abort) begin
            step_q    <= 1'b0;
            aborted_q <= 1'b1;
            cnt_q     <= GAP_LOAD;
            state_q   <= GAP;
          end else if (cnt_zero) begin
            step_q <= 1'b0;
            if (last_pulse) begin
              cnt_q   <= GAP_LOAD;
              state_q <= GAP;
            end else begin
              cnt_q   <= LO_LOAD;
              state_q <= STEP_LO;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STEP_LO: begin
          if (abort) begin
            aborted_q <= 1'b1;
            cnt_q     <= GAP_LOAD;
            state_q   <= GAP;
          end else if (cnt_zero) begin
            step_q   <= 1'b1;
            pulses_q <= last_pulse ? pulses_q : pulses_q + 6'd1;
            cnt_q    <= HI_LOAD;
            state_q  <= STEP_HI;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_out    = step_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cmd_error   = cmd_error_q;
  assign pulses_sent = pulses_q;

endmodule
